// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
//   Shared definitions for the load/store unit: RV32I load/store funct3
//   encodings, the sequencing FSM state type and small helpers that decode
//   access size and legality from funct3.
//
//   Contents:
//     ADDR_W         memory byte-address width (16)
//     F3_*           funct3 encodings for B/H/W/BU/HU
//     lsu_state_e    IDLE, ACC0, ACC1, RESP
//     size_mask()    byte-lane mask of an access before lane shifting
//     size_bytes()   access size in bytes (1, 2, 4)
//     funct3_legal() whether a funct3 is legal for a load or a store
//     is_split()     whether an access straddles a word boundary
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam int unsigned ADDR_W = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    // Lane mask for an access starting at lane 0.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        logic [3:0] m;
        case (f3)
            F3_B, F3_BU: m = 4'b0001;
            F3_H, F3_HU: m = 4'b0011;
            F3_W:        m = 4'b1111;
            default:     m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] f3);
        logic [2:0] s;
        case (f3)
            F3_B, F3_BU: s = 3'd1;
            F3_H, F3_HU: s = 3'd2;
            F3_W:        s = 3'd4;
            default:     s = 3'd0;
        endcase
        return s;
    endfunction

    // Stores only know signed encodings; the unsigned forms are load-only.
    function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 inside {F3_B, F3_H, F3_W});
        else    ok = (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        return ok;
    endfunction

    // Offset plus size beyond 4 bytes means the access touches the next word.
    function automatic logic is_split(input logic [1:0] off, input logic [2:0] f3);
        return (({1'b0, off} + size_bytes(f3)) > 3'd4);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
//   Bundles the execute-stage request/response handshake and the data-memory
//   port of the load/store unit.
//
//   Core side : i_req, i_we, i_funct3, i_addr, i_wdata  -> LSU
//               o_ready, o_done, o_err, o_rdata          <- LSU
//   Memory    : o_addr, o_wdata, o_bmask, o_wren         <- LSU
//               i_rdata (combinational w.r.t. o_addr)    -> LSU
//
//   Modports:
//     slave  - the LSU itself (consumes i_*, produces o_*)
//     master - the environment: core stage plus memory model
// -----------------------------------------------------------------------------
interface lsu_ctrl_if;
    import lsu_pkg::*;

    // request from execute stage
    logic              i_req;
    logic              i_we;
    logic [2:0]        i_funct3;
    logic [31:0]       i_addr;
    logic [31:0]       i_wdata;

    // response to execute stage
    logic              o_ready;
    logic              o_done;
    logic              o_err;
    logic [31:0]       o_rdata;

    // data-memory port
    logic [ADDR_W-1:0] o_addr;
    logic [31:0]       o_wdata;
    logic [3:0]        o_bmask;
    logic              o_wren;
    logic [31:0]       i_rdata;

    modport slave (
        input  i_req, i_we, i_funct3, i_addr, i_wdata, i_rdata,
        output o_ready, o_done, o_err, o_rdata,
        output o_addr, o_wdata, o_bmask, o_wren
    );

    modport master (
        output i_req, i_we, i_funct3, i_addr, i_wdata, i_rdata,
        input  o_ready, o_done, o_err, o_rdata,
        input  o_addr, o_wdata, o_bmask, o_wren
    );

endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
//   Purely combinational lane steering for the load/store unit.
//   Store side: shifts the right-justified store data and the size mask into
//   the byte lanes of the first (second=0) or second (second=1) word access.
//   Load side: merges the two captured memory words, shifts the addressed
//   bytes down to bit 0 and sign/zero-extends according to funct3.
//
//   Ports:
//     funct3     in   3  access type (B/H/W/BU/HU)
//     off        in   2  byte offset inside the first word
//     second     in   1  0 = first word access, 1 = second word access
//     wdata      in  32  store data, right-justified
//     lo, hi     in  32  memory words captured in the first/second access
//     bmask      out  4  byte-lane mask for the current access
//     mem_wdata  out 32  lane-shifted write data for the current access
//     load_data  out 32  merged and extended load result
// -----------------------------------------------------------------------------
module lsu_align import lsu_pkg::*; (
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        second,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [31:0] hi,
    output logic [3:0]  bmask,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data
);

    // Shifting into a double-width vector yields both words at once: the low
    // half is the first access, the high half is what spilled past the word
    // boundary (equivalent to shifting right by 4-off for the second access).
    logic [7:0]  mask_wide;
    logic [63:0] wdata_wide;
    logic [31:0] data;

    // NOTE: every signal written here gets a value on every path through the
    // block; a missing branch would otherwise infer a latch.
    always_comb begin
        mask_wide  = {4'b0000, size_mask(funct3)} << off;
        wdata_wide = {32'h0000_0000, wdata} << {off, 3'b000};

        bmask      = second ? mask_wide[7:4]   : mask_wide[3:0];
        mem_wdata  = second ? wdata_wide[63:32] : wdata_wide[31:0];

        data = 32'({hi, lo} >> {off, 3'b000});

        case (funct3)
            F3_B:    load_data = {{24{data[7]}}, data[7:0]};
            F3_H:    load_data = {{16{data[15]}}, data[15:0]};
            F3_W:    load_data = data;
            F3_BU:   load_data = {24'h00_0000, data[7:0]};
            F3_HU:   load_data = {16'h0000, data[15:0]};
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
//   Load/store unit acting as initiator on the byte-masked data memory.
//   Accepts one request at a time from the execute stage, runs one or two
//   word accesses, and returns a single-cycle o_done with the extended load
//   data (or an error flag).
//
//   Sequence: IDLE -> ACC0 [-> ACC1] -> RESP -> IDLE
//             IDLE -> RESP directly for illegal requests (o_err=1).
//
//   Configuration macro:
//     LSU_MISALIGNED_SPLIT_EN  defined: accesses crossing a word boundary are
//                              performed as two word accesses (ACC0, ACC1).
//                              undefined: such accesses return o_err=1 with no
//                              memory traffic; ACC1 and the hi word register
//                              do not exist.
//
//   Ports:
//     i_clk    in   clock
//     i_reset  in   asynchronous reset, active low
//     bus      slave modport of lsu_ctrl_if (request, response, memory port)
//
//   A split store is not atomic: a reset between ACC0 and ACC1 leaves the
//   first half written.
// -----------------------------------------------------------------------------
module lsu_ctrl import lsu_pkg::*; (
    input  logic       i_clk,
    input  logic       i_reset,
    lsu_ctrl_if.slave  bus
);

    lsu_state_e        state;
    lsu_state_e        state_nxt;

    // request captured at accept
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              err_q;

    // load words captured from memory
    logic [31:0]       lo_q;
    logic [31:0]       hi_q;

    logic              accept;
    logic              req_err;
    logic              second;
    logic [ADDR_W-1:0] base_addr;

    logic [3:0]        al_bmask;
    logic [31:0]       al_wdata;
    logic [31:0]       al_load;

    // Upper address bits are outside the 64 KiB data memory and are dropped.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^bus.i_addr[31:ADDR_W];

    assign accept    = (state == IDLE) && bus.i_req;
    assign base_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic split_q;

    assign split_q = is_split(addr_q[1:0], f3_q);
    assign req_err = !funct3_legal(bus.i_we, bus.i_funct3);
    assign second  = (state == ACC1);
`else
    logic req_split;

    // Without the split path a boundary-crossing access is simply rejected.
    assign req_split = is_split(bus.i_addr[1:0], bus.i_funct3);
    assign req_err   = !funct3_legal(bus.i_we, bus.i_funct3) || req_split;
    assign second    = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // State and request registers
    // -------------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking assignments so each register
    // samples the pre-edge value of every other register, independent of
    // statement order.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= bus.i_we;
            f3_q    <= bus.i_funct3;
            addr_q  <= bus.i_addr[ADDR_W-1:0];
            wdata_q <= bus.i_wdata;
            err_q   <= req_err;
        end
    end

    // Memory read data is combinational on o_addr, so the word is taken at
    // the end of the access cycle that presented its address.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            lo_q <= 32'h0000_0000;
        end else if ((state == ACC0) && !we_q) begin
            lo_q <= bus.i_rdata;
        end
    end

`ifdef LSU_MISALIGNED_SPLIT_EN
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            hi_q <= 32'h0000_0000;
        end else if ((state == ACC1) && !we_q) begin
            hi_q <= bus.i_rdata;
        end
    end
`else
    assign hi_q = 32'h0000_0000;
`endif

    // -------------------------------------------------------------------------
    // Lane steering and load merge
    // -------------------------------------------------------------------------
    lsu_align u_align (
        .funct3    (f3_q),
        .off       (addr_q[1:0]),
        .second    (second),
        .wdata     (wdata_q),
        .lo        (lo_q),
        .hi        (hi_q),
        .bmask     (al_bmask),
        .mem_wdata (al_wdata),
        .load_data (al_load)
    );

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        bus.o_ready = 1'b0;
        bus.o_done  = 1'b0;
        bus.o_err   = 1'b0;
        bus.o_rdata = 32'h0000_0000;
        bus.o_addr  = '0;
        bus.o_wdata = 32'h0000_0000;
        bus.o_bmask = 4'b0000;
        bus.o_wren  = 1'b0;

        case (state)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_req) begin
                    state_nxt = req_err ? RESP : ACC0;
                end
            end

            ACC0: begin
                bus.o_addr  = base_addr;
                bus.o_bmask = al_bmask;
                bus.o_wdata = al_wdata;
                bus.o_wren  = we_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
                state_nxt   = split_q ? ACC1 : RESP;
`else
                state_nxt   = RESP;
`endif
            end

            ACC1: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                // Wraps from 0xFFFC to 0x0000 at the top of the space.
                bus.o_addr  = base_addr + ADDR_W'(4);
                bus.o_bmask = al_bmask;
                bus.o_wdata = al_wdata;
                bus.o_wren  = we_q;
                state_nxt   = RESP;
`else
                state_nxt   = IDLE;
`endif
            end

            RESP: begin
                bus.o_done  = 1'b1;
                bus.o_err   = err_q;
                bus.o_rdata = (we_q || err_q) ? 32'h0000_0000 : al_load;
                state_nxt   = IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Directed bench for lsu_ctrl. A byte-level reference model predicts, per
//   request, the memory accesses (address, lanes, data) and the response, and
//   every cycle the DUT outputs are compared against that prediction (idle
//   values when nothing is expected). A separate byte memory answers the DUT's
//   memory port so load results depend on what the DUT actually wrote.
//   Works with LSU_MISALIGNED_SPLIT_EN defined or not.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;
    import lsu_pkg::*;

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_reset;

    always #5 i_clk = ~i_clk;

    lsu_ctrl_if bus ();

    lsu_ctrl dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    // ---------------------------------------------------------------------
    // Environment memory (driven by the DUT) and reference memory (model)
    // ---------------------------------------------------------------------
    logic [7:0] env_mem [0:65535];
    logic [7:0] ref_mem [0:65535];

    assign bus.i_rdata = {env_mem[bus.o_addr + 16'd3], env_mem[bus.o_addr + 16'd2],
                          env_mem[bus.o_addr + 16'd1], env_mem[bus.o_addr]};

    always @(posedge i_clk) begin
        if (bus.o_wren) begin
            for (int l = 0; l < 4; l++) begin
                if (bus.o_bmask[l]) env_mem[bus.o_addr + 16'(l)] <= bus.o_wdata[8*l +: 8];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Expectation bookkeeping
    // ---------------------------------------------------------------------
    typedef struct packed {
        logic        ready;
        logic        done;
        logic        err;
        logic [31:0] rdata;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bmask;
        logic        wren;
    } obs_t;

    typedef struct {
        int   cyc;
        int   kind;   // 0 first access, 1 second access, 2 response
        obs_t o;
    } exp_t;

    exp_t exp_q[$];
    obs_t cap [3];
    int   cyc;
    int   total;
    int   bad;

    function automatic obs_t idle_obs();
        obs_t o;
        o       = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ready = bus.o_ready;
        o.done  = bus.o_done;
        o.err   = bus.o_err;
        o.rdata = bus.o_rdata;
        o.addr  = bus.o_addr;
        o.wdata = bus.o_wdata;
        o.bmask = bus.o_bmask;
        o.wren  = bus.o_wren;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance to
    // just after the next rising edge where stimulus is applied.
    task automatic tick();
        obs_t act;
        obs_t want;
        int   kind;
        @(negedge i_clk);
        act  = sample();
        want = idle_obs();
        kind = -1;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            want = exp_q[0].o;
            kind = exp_q[0].kind;
            void'(exp_q.pop_front());
        end
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL cycle%0d phase%0d: got rdy=%b done=%b err=%b rdata=%h addr=%h wdata=%h bmask=%b wren=%b expected rdy=%b done=%b err=%b rdata=%h addr=%h wdata=%h bmask=%b wren=%b",
                     cyc, kind, act.ready, act.done, act.err, act.rdata, act.addr, act.wdata, act.bmask, act.wren,
                     want.ready, want.done, want.err, want.rdata, want.addr, want.wdata, want.bmask, want.wren);
        end
        if (kind >= 0) cap[kind] = act;
        @(posedge i_clk);
        cyc++;
        #2;
    endtask

    // Reference model: from the request alone, derive which bytes are
    // touched, how they fall into words, and what a load must return.
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [15:0] a,
                             input logic [31:0] wd, input int c0, output int nacc);
        int          size;
        bit          legal;
        bit          split;
        bit          err;
        int          lane;
        logic [15:0] base;
        logic [63:0] wide;
        logic [31:0] val;
        logic [31:0] ext;
        exp_t        e;

        legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        split = (int'(a[1:0]) + size) > 4;
        err   = !legal || (split && !SPLIT_EN);
        nacc  = err ? 0 : (split ? 2 : 1);
        base  = {a[15:2], 2'b00};
        wide  = {32'h0, wd} << (8 * a[1:0]);

        for (int j = 0; j < nacc; j++) begin
            e.cyc   = c0 + 1 + j;
            e.kind  = j;
            e.o     = '0;
            e.o.addr  = base + 16'(4 * j);
            e.o.wren  = we;
            e.o.wdata = (j == 0) ? wide[31:0] : wide[63:32];
            for (int k = 0; k < size; k++) begin
                lane = int'(a[1:0]) + k;
                if (lane / 4 == j) e.o.bmask[lane % 4] = 1'b1;
            end
            exp_q.push_back(e);
        end

        val = 32'h0;
        if (!we && !err) begin
            for (int k = 0; k < size; k++) val[8*k +: 8] = ref_mem[a + 16'(k)];
        end
        case (f3)
            3'b000:  ext = {{24{val[7]}}, val[7:0]};
            3'b001:  ext = {{16{val[15]}}, val[15:0]};
            3'b100:  ext = {24'h0, val[7:0]};
            3'b101:  ext = {16'h0, val[15:0]};
            default: ext = val;
        endcase
        if (we && !err) begin
            for (int k = 0; k < size; k++) ref_mem[a + 16'(k)] = wd[8*k +: 8];
        end

        e.cyc     = c0 + 1 + nacc;
        e.kind    = 2;
        e.o       = '0;
        e.o.done  = 1'b1;
        e.o.err   = err;
        e.o.rdata = (!we && !err) ? ext : 32'h0;
        exp_q.push_back(e);
    endtask

    // Issue one request; optionally keep a different request asserted while
    // the LSU is busy, which must be ignored.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input bit poke);
        int c0;
        int nacc;
        bus.i_req    = 1'b1;
        bus.i_we     = we;
        bus.i_funct3 = f3;
        bus.i_addr   = addr;
        bus.i_wdata  = wd;
        c0 = cyc;
        model_req(we, f3, addr[15:0], wd, c0, nacc);
        tick();
        if (poke) begin
            bus.i_req    = 1'b1;
            bus.i_we     = ~we;
            bus.i_funct3 = F3_W;
            bus.i_addr   = 32'h0000_0100;
            bus.i_wdata  = 32'hCAFE_F00D;
        end else begin
            bus.i_req = 1'b0;
        end
        repeat (nacc) tick();
        bus.i_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        int c0;
        int nacc;

        total = 0;
        bad   = 0;
        cyc   = 0;
        i_reset      = 1'b0;
        bus.i_req    = 1'b0;
        bus.i_we     = 1'b0;
        bus.i_funct3 = 3'b000;
        bus.i_addr   = 32'h0;
        bus.i_wdata  = 32'h0;

        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        // word 0x0020 holds 0x8001_1234
        env_mem[16'h20] = 8'h34; ref_mem[16'h20] = 8'h34;
        env_mem[16'h21] = 8'h12; ref_mem[16'h21] = 8'h12;
        env_mem[16'h22] = 8'h01; ref_mem[16'h22] = 8'h01;
        env_mem[16'h23] = 8'h80; ref_mem[16'h23] = 8'h80;

        @(posedge i_clk);
        #2;
        repeat (3) tick();
        check("rst_ready", 32'(bus.o_ready), 32'd1);
        check("rst_done",  32'(bus.o_done),  32'd0);
        check("rst_wren",  32'(bus.o_wren),  32'd0);
        i_reset = 1'b1;
        repeat (2) tick();

        // aligned word store; upper address bits must be ignored
        do_req(1'b1, F3_W, 32'hABCD_0010, 32'hDEAD_BEEF, 1'b0);
        check("sw_addr",  32'(cap[0].addr),  32'h0010);
        check("sw_bmask", 32'(cap[0].bmask), 32'hF);
        check("sw_wren",  32'(cap[0].wren),  32'd1);
        check("sw_err",   32'(cap[2].err),   32'd0);

        // byte store into the top lane, then signed/unsigned byte loads
        do_req(1'b1, F3_B, 32'h0000_0013, 32'h0000_00A5, 1'b0);
        check("sb_bmask", 32'(cap[0].bmask), 32'b1000);
        check("sb_lane3", 32'(cap[0].wdata[31:24]), 32'hA5);
        do_req(1'b0, F3_B, 32'h0000_0013, 32'h0, 1'b0);
        check("lb_rdata", cap[2].rdata, 32'hFFFF_FFA5);
        do_req(1'b0, F3_BU, 32'h0000_0013, 32'h0, 1'b0);
        check("lbu_rdata", cap[2].rdata, 32'h0000_00A5);

        // halfword loads from the upper half of word 0x0020
        do_req(1'b0, F3_H, 32'h0000_0022, 32'h0, 1'b0);
        check("lh_bmask", 32'(cap[0].bmask), 32'b1100);
        check("lh_rdata", cap[2].rdata, 32'hFFFF_8001);
        do_req(1'b0, F3_HU, 32'h0000_0022, 32'h0, 1'b0);
        check("lhu_rdata", cap[2].rdata, 32'h0000_8001);

        // word load while another request is held during the busy phase
        do_req(1'b0, F3_W, 32'h0000_0010, 32'h0, 1'b1);
        check("lw_poke_rdata", cap[2].rdata, 32'hA5AD_BEEF);

        // misaligned word store/load crossing into the next word
        do_req(1'b1, F3_W, 32'h0000_0031, 32'h1122_3344, 1'b0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        check("sws_a0_addr",  32'(cap[0].addr),  32'h0030);
        check("sws_a0_bmask", 32'(cap[0].bmask), 32'b1110);
        check("sws_a0_wdata", cap[0].wdata,      32'h2233_4400);
        check("sws_a1_addr",  32'(cap[1].addr),  32'h0034);
        check("sws_a1_bmask", 32'(cap[1].bmask), 32'b0001);
        check("sws_a1_lane0", 32'(cap[1].wdata[7:0]), 32'h11);
`else
        check("sws_err", 32'(cap[2].err), 32'd1);
`endif
        do_req(1'b0, F3_W, 32'h0000_0031, 32'h0, 1'b0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        check("lws_rdata", cap[2].rdata, 32'h1122_3344);
`else
        check("lws_err", 32'(cap[2].err), 32'd1);
`endif

        // word access at the top of the address space
        do_req(1'b0, F3_W, 32'h0000_FFFE, 32'h0, 1'b0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        check("wrap_a0_addr", 32'(cap[0].addr), 32'hFFFC);
        check("wrap_a1_addr", 32'(cap[1].addr), 32'h0000);
`else
        check("wrap_err", 32'(cap[2].err), 32'd1);
`endif

        // misaligned halfwords: one inside a word, one crossing
        do_req(1'b1, F3_H, 32'h0000_0003, 32'h0000_BEEF, 1'b0);
        do_req(1'b0, F3_H, 32'h0000_0003, 32'h0, 1'b0);
`ifdef LSU_MISALIGNED_SPLIT_EN
        check("lhs_rdata", cap[2].rdata, 32'hFFFF_BEEF);
`endif
        do_req(1'b1, F3_H, 32'h0000_0041, 32'h0000_7ABC, 1'b0);
        do_req(1'b0, F3_HU, 32'h0000_0041, 32'h0, 1'b0);
        check("lhu_mid_rdata", cap[2].rdata, 32'h0000_7ABC);

        // illegal encodings
        do_req(1'b1, 3'b100, 32'h0000_0050, 32'h1234_5678, 1'b0);
        check("sbu_err",   32'(cap[2].err),   32'd1);
        check("sbu_rdata", cap[2].rdata,      32'h0);
        do_req(1'b1, 3'b011, 32'h0000_0050, 32'h1234_5678, 1'b0);
        do_req(1'b0, 3'b110, 32'h0000_0050, 32'h0, 1'b0);
        check("l110_err", 32'(cap[2].err), 32'd1);
        do_req(1'b0, F3_W, 32'h0000_0050, 32'h0, 1'b0);

        // reset in the middle of an access
        bus.i_req    = 1'b1;
        bus.i_we     = 1'b0;
        bus.i_funct3 = F3_W;
        bus.i_wdata  = 32'h0;
        c0 = cyc;
`ifdef LSU_MISALIGNED_SPLIT_EN
        bus.i_addr = 32'h0000_0031;
        model_req(1'b0, F3_W, 16'h0031, 32'h0, c0, nacc);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        tick();
        bus.i_req = 1'b0;
        tick();
`else
        bus.i_addr = 32'h0000_0010;
        model_req(1'b0, F3_W, 16'h0010, 32'h0, c0, nacc);
        exp_q.delete();
        tick();
        bus.i_req = 1'b0;
`endif
        i_reset = 1'b0;
        #1;
        check("midrst_ready", 32'(bus.o_ready), 32'd1);
        check("midrst_done",  32'(bus.o_done),  32'd0);
        check("midrst_addr",  32'(bus.o_addr),  32'h0);
        check("midrst_bmask", 32'(bus.o_bmask), 32'h0);
        repeat (2) tick();
        i_reset = 1'b1;
        tick();

        // recovery after reset
        do_req(1'b0, F3_W, 32'h0000_0010, 32'h0, 1'b0);
        check("post_rst_rdata", cap[2].rdata, 32'hA5AD_BEEF);
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
